mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 60 ++++++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_wram_sp.sv | 24 ++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and address map for the mem_responder slice: FSM states,
// decoded regions and the region base/limit constants.
package mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_DONE,
    RELEASE
  } state_e;

  typedef enum logic [2:0] {
    RGN_ROM,
    RGN_WRAM,
    RGN_ECHO,
    RGN_BOOT,
    RGN_NONE
  } region_e;

  localparam logic [15:0] ROM_BASE    = 16'h0000;
  localparam logic [15:0] ROM_LIMIT   = 16'h00FF;
  localparam logic [15:0] WRAM_BASE   = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT  = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE   = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT  = 16'hFDFF;
  localparam logic [15:0] ECHO_OFFSET = 16'h2000;
  localparam logic [15:0] BOOT_REG    = 16'hFF50;

  // Offset compare avoids an always-true "addr >= 0" test for the ROM region.
  function automatic logic inRange(input logic [15:0] addr,
                                   input logic [15:0] base,
                                   input logic [15:0] limit);
    return (addr - base) <= (limit - base);
  endfunction

  function automatic region_e decodeRegion(input logic [15:0] addr,
                                           input logic overlayOn,
                                           input logic bootRegOn);
    region_e rgn;
    rgn = RGN_NONE;
    if (overlayOn && inRange(addr, ROM_BASE, ROM_LIMIT))
      rgn = RGN_ROM;
    else if (inRange(addr, WRAM_BASE, WRAM_LIMIT))
      rgn = RGN_WRAM;
    else if (inRange(addr, ECHO_BASE, ECHO_LIMIT))
      rgn = RGN_ECHO;
    else if (bootRegOn && (addr == BOOT_REG))
      rgn = RGN_BOOT;
    return rgn;
  endfunction

  function automatic logic [15:0] wramIndex(input logic [15:0] addr,
                                            input region_e rgn);
    logic [15:0] physAddr;
    physAddr = (rgn == RGN_ECHO) ? (addr - ECHO_OFFSET) : addr;
    return physAddr - WRAM_BASE;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side bus between an initiator and mem_responder: address/data buses,
// request strobes, tri-state enable and the ready pulse.
interface mem_responder_if;

  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic        mem_ready;

  modport master (
    output addr_in, data_in, mem_cs, mem_oe, mem_we,
    input  data_out, data_oe, mem_ready
  );

  modport slave (
    input  addr_in, data_in, mem_cs, mem_oe, mem_we,
    output data_out, data_oe, mem_ready
  );

endinterface

// File: rtl/mem_responder_wram_sp.sv
// wram_sp: single-port synchronous work RAM, 2**WRAM_AW x 8, one-cycle read.
// Contents are deliberately not reset.
module wram_sp #(
  parameter int WRAM_AW = 13
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [WRAM_AW-1:0] addr_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         rdata_o
);

  logic [7:0] mem [0:(2**WRAM_AW)-1];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i)
        mem[addr_i] <= wdata_i;
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: decodes CPU accesses onto boot ROM, work RAM (+echo) and the
// boot register. Define BOOTROM_OVERLAY_EN to enable the boot ROM overlay.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WRAM_AW = 13,
  parameter int ROM_AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_en,
  input  logic [7:0]        rom_dout,
  output logic              boot_off
);

  state_e      state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdPhase_q;
  logic        latchAddr, latchData;
  logic        overlayOn, bootRegOn;
  region_e     region;
  logic [7:0]  readMux;
  logic [7:0]  wramRdata;
  logic        wramSel, wramEn, wramWe;

`ifdef BOOTROM_OVERLAY_EN
  logic bootOff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bootOff_q <= 1'b0;
    else if (state_q == WR_DONE && region == RGN_BOOT && wdata_q[0])
      bootOff_q <= 1'b1;
  end

  assign boot_off  = bootOff_q;
  assign overlayOn = !bootOff_q;
  assign bootRegOn = 1'b1;
  assign rom_en    = (state_q == RD_WAIT) && (region == RGN_ROM);
`else
  assign boot_off  = 1'b1;
  assign overlayOn = 1'b0;
  assign bootRegOn = 1'b0;
  assign rom_en    = 1'b0;
`endif

  assign region   = decodeRegion(addr_q, overlayOn, bootRegOn);
  assign rom_addr = ROM_AW'(addr_q);
  assign wramSel  = (region == RGN_WRAM) || (region == RGN_ECHO);
  assign wramEn   = wramSel && ((state_q == RD_WAIT) || (state_q == WR_DONE));
  assign wramWe   = wramSel && (state_q == WR_DONE);

  wram_sp #(.WRAM_AW(WRAM_AW)) u_wram (
    .clk     (clk),
    .en_i    (wramEn),
    .we_i    (wramWe),
    .addr_i  (WRAM_AW'(wramIndex(addr_q, region))),
    .wdata_i (wdata_q),
    .rdata_o (wramRdata)
  );

  always_comb begin
    readMux = 8'hFF;
    case (region)
      RGN_ROM:            readMux = rom_dout;
      RGN_WRAM, RGN_ECHO: readMux = wramRdata;
      RGN_BOOT:           readMux = {7'h7F, boot_off};
      default:            readMux = 8'hFF;
    endcase
  end

  // RD_WAIT spans two cycles: issue the synchronous read, then capture it.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    latchAddr = 1'b0;
    latchData = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_cs && bus.mem_we) begin
          latchAddr = 1'b1;
          latchData = 1'b1;
          state_d   = WR_DONE;
        end else if (bus.mem_cs && bus.mem_oe) begin
          latchAddr = 1'b1;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rdPhase_q) begin
          rdata_d = readMux;
          state_d = RD_DONE;
        end
      end
      RD_DONE: state_d = RELEASE;
      WR_DONE: state_d = RELEASE;
      RELEASE: if (!bus.mem_cs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      rdPhase_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      rdPhase_q <= (state_q == RD_WAIT) && !rdPhase_q;
      if (latchAddr) addr_q  <= bus.addr_in;
      if (latchData) wdata_q <= bus.data_in;
    end
  end

  assign bus.data_out  = rdata_q;
  assign bus.data_oe   = (state_q == RD_DONE);
  assign bus.mem_ready = (state_q == RD_DONE) || (state_q == WR_DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; expectations adapt to
// whether BOOTROM_OVERLAY_EN is defined.
module tb_mem_responder;

`ifdef BOOTROM_OVERLAY_EN
  localparam logic OVL = 1'b1;
`else
  localparam logic OVL = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] romAddr;
  logic       romEn;
  logic [7:0] romDout;
  logic       bootOff;
  logic [7:0] romMem [0:255];
  int         checks;
  int         errors;

  mem_responder_if bus ();

  mem_responder #(.WRAM_AW(13), .ROM_AW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_addr (romAddr),
    .rom_en   (romEn),
    .rom_dout (romDout),
    .boot_off (bootOff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous boot ROM model with one-cycle read latency.
  always @(posedge clk) begin
    if (romEn) romDout <= romMem[romAddr];
  end

  // Drives one access, holds mem_cs for 'hold' cycles and records what was seen.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic oe, input logic we, input int hold,
                               output logic [7:0] rd, output int lat,
                               output int pulses, output logic oeSeen,
                               output logic strayOe, output logic romEnSeen);
    @(negedge clk);
    bus.addr_in = a;
    bus.data_in = d;
    bus.mem_oe  = oe;
    bus.mem_we  = we;
    bus.mem_cs  = 1'b1;
    rd = 8'h00; lat = 0; pulses = 0;
    oeSeen = 1'b0; strayOe = 1'b0; romEnSeen = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (romEn) romEnSeen = 1'b1;
      if (bus.data_oe) begin
        oeSeen = 1'b1;
        if (!bus.mem_ready) strayOe = 1'b1;
      end
      if (bus.mem_ready) begin
        pulses++;
        if (lat == 0) begin
          lat = i;
          rd  = bus.data_out;
        end
      end
    end
    bus.mem_cs = 1'b0;
    bus.mem_oe = 1'b0;
    bus.mem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.mem_cs = 1'b0; bus.mem_oe = 1'b0; bus.mem_we = 1'b0;
    bus.addr_in = 16'h0000; bus.data_in = 8'h00;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_oe: got %b expected 0", bus.data_oe); end
    checks++;
    if (bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_ready: got %b expected 0", bus.mem_ready); end
    checks++;
    if (romEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_en: got %b expected 0", romEn); end
    checks++;
    if (bus.data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 00", bus.data_out); end
    checks++;
    if (bootOff !== !OVL) begin errors++; $display("[TB] FAIL reset_boot_off: got %b expected %b", bootOff, !OVL); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rom_read;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'h0000, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== (OVL ? 8'h31 : 8'hFF)) begin errors++; $display("[TB] FAIL rom_read_0000: got %h expected %h", rd, OVL ? 8'h31 : 8'hFF); end
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL rom_read_latency: got %0d expected 3", lat); end
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL rom_read_pulses: got %0d expected 1", pulses); end
    checks++;
    if (oeSeen !== 1'b1 || strayOe !== 1'b0) begin errors++; $display("[TB] FAIL rom_read_oe: got seen=%b stray=%b expected seen=1 stray=0", oeSeen, strayOe); end
    checks++;
    if (romEnSeen !== OVL) begin errors++; $display("[TB] FAIL rom_read_rom_en: got %b expected %b", romEnSeen, OVL); end
    applyStimulus(16'h0042, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== (OVL ? 8'h18 : 8'hFF)) begin errors++; $display("[TB] FAIL rom_read_0042: got %h expected %h", rd, OVL ? 8'h18 : 8'hFF); end
  endtask

  task automatic test_wram;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'hC123, 8'hA5, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (pulses !== 1 || oeSeen !== 1'b0) begin errors++; $display("[TB] FAIL wram_write_c123: got pulses=%0d oe=%b expected pulses=1 oe=0", pulses, oeSeen); end
    applyStimulus(16'hE123, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hA5) begin errors++; $display("[TB] FAIL wram_echo_read_e123: got %h expected a5", rd); end
    applyStimulus(16'hC123, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hA5 || lat !== 3) begin errors++; $display("[TB] FAIL wram_read_c123: got %h lat %0d expected a5 lat 3", rd, lat); end
    applyStimulus(16'hFD00, 8'h5A, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    applyStimulus(16'hDD00, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("[TB] FAIL wram_echo_write_fd00: got %h expected 5a", rd); end
  endtask

  task automatic test_unmapped;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'h8000, 8'h3C, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL unmapped_write_pulse: got %0d expected 1", pulses); end
    applyStimulus(16'h8000, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hFF || pulses !== 1) begin errors++; $display("[TB] FAIL unmapped_read_8000: got %h pulses %0d expected ff pulses 1", rd, pulses); end
    applyStimulus(16'hFF4F, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("[TB] FAIL unmapped_read_ff4f: got %h expected ff", rd); end
  endtask

  task automatic test_both_strobes;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'hC010, 8'h77, 1'b1, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (oeSeen !== 1'b0 || pulses !== 1) begin errors++; $display("[TB] FAIL both_strobes_write: got oe=%b pulses=%0d expected oe=0 pulses=1", oeSeen, pulses); end
    applyStimulus(16'hC010, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'h77) begin errors++; $display("[TB] FAIL both_strobes_readback: got %h expected 77", rd); end
  endtask

  task automatic test_hold;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'hC123, 8'h00, 1'b1, 1'b0, 10, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (pulses !== 1 || strayOe !== 1'b0) begin errors++; $display("[TB] FAIL hold_read_pulses: got %0d stray %b expected 1 stray 0", pulses, strayOe); end
    applyStimulus(16'hC200, 8'h11, 1'b0, 1'b1, 10, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (pulses !== 1) begin errors++; $display("[TB] FAIL hold_write_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_boot;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'hFF50, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== (OVL ? 8'hFE : 8'hFF)) begin errors++; $display("[TB] FAIL boot_reg_read_before: got %h expected %h", rd, OVL ? 8'hFE : 8'hFF); end
    applyStimulus(16'hFF50, 8'hFE, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (bootOff !== !OVL) begin errors++; $display("[TB] FAIL boot_write_bit0_clear: got %b expected %b", bootOff, !OVL); end
    applyStimulus(16'hFF50, 8'h01, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (bootOff !== 1'b1) begin errors++; $display("[TB] FAIL boot_write_set: got %b expected 1", bootOff); end
    applyStimulus(16'h0000, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hFF || romEnSeen !== 1'b0) begin errors++; $display("[TB] FAIL boot_off_rom_read: got %h rom_en %b expected ff rom_en 0", rd, romEnSeen); end
    applyStimulus(16'hFF50, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'hFF) begin errors++; $display("[TB] FAIL boot_reg_read_after: got %h expected ff", rd); end
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] rd; int lat, pulses; logic oeSeen, strayOe, romEnSeen;
    applyStimulus(16'hC000, 8'h12, 1'b0, 1'b1, 4, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    @(negedge clk);
    bus.addr_in = 16'hC000;
    bus.data_in = 8'h55;
    bus.mem_we  = 1'b1;
    bus.mem_cs  = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (bus.mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_write_in_wr_done: got %b expected 1", bus.mem_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.data_oe !== 1'b0 || bus.mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_write_async_reset: got oe=%b ready=%b expected 0 0", bus.data_oe, bus.mem_ready); end
    checks++;
    if (bootOff !== !OVL) begin errors++; $display("[TB] FAIL mid_write_boot_off: got %b expected %b", bootOff, !OVL); end
    bus.mem_cs = 1'b0;
    bus.mem_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(16'hC000, 8'h00, 1'b1, 1'b0, 6, rd, lat, pulses, oeSeen, strayOe, romEnSeen);
    checks++;
    if (rd !== 8'h12) begin errors++; $display("[TB] FAIL mid_write_not_committed: got %h expected 12", rd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    romDout = 8'h00;
    for (int i = 0; i < 256; i++) romMem[i] = 8'(i) ^ 8'h5A;
    romMem[0] = 8'h31;
    test_reset();
    test_rom_read();
    test_wram();
    test_unmapped();
    test_both_strobes();
    test_hold();
    test_boot();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
